// File: rtl/decoder_2_to_4_hold_pkg.sv
// Shared state encodings and code / one-hot constants for the 2-to-4 decoder
// and its matching 4-to-2 encoder.
package decoder_defs;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [1:0] CODE_NULL = 2'b00;
    localparam logic [1:0] CODE_1    = 2'b01;
    localparam logic [1:0] CODE_2    = 2'b10;
    localparam logic [1:0] CODE_3    = 2'b11;

    localparam logic [3:0] OH_NULL = 4'b0000;
    localparam logic [3:0] OH_1    = 4'b0010;
    localparam logic [3:0] OH_2    = 4'b0100;
    localparam logic [3:0] OH_3    = 4'b1000;

endpackage

// File: rtl/decoder_2_to_4_hold_comb.sv
// Pure combinational code-to-one-hot map. Bit 0 of the one-hot is never driven
// because code 00 is the null code.
module decoder_2_to_4_hold_comb
    import decoder_defs::*;
(
    input  logic [1:0] i_code,
    output logic [3:0] o_onehot
);

    always_comb begin
        case (i_code)
            CODE_1:  o_onehot = OH_1;
            CODE_2:  o_onehot = OH_2;
            CODE_3:  o_onehot = OH_3;
            default: o_onehot = OH_NULL;
        endcase
    end

endmodule

// File: rtl/decoder_2_to_4_hold.sv
// Registered 2-to-4 decoder with valid/ready handshake and a HOLD_CYCLES strobe.
// Define DECODER_2_TO_4_ABORT_EN to add the i_abort input that cuts a hold short.
module decoder_2_to_4_hold
    import decoder_defs::*;
#(
    parameter int HOLD_CYCLES = 4,
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_in,
    input  logic       i_in_valid,
`ifdef DECODER_2_TO_4_ABORT_EN
    input  logic       i_abort,
`endif
    output logic       o_in_ready,
    output logic [3:0] o_out,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_out;
    logic             r_done;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_out_nxt;
    logic             w_done_nxt;
    logic [3:0]       w_decoded;
    logic             w_abort;

`ifdef DECODER_2_TO_4_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    decoder_2_to_4_hold_comb u_comb (
        .i_code   (i_in),
        .o_onehot (w_decoded)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Null codes are consumed without leaving IDLE.
                if (i_in_valid && (i_in != CODE_NULL)) begin
                    w_state_nxt = ST_HOLD;
                    w_out_nxt   = w_decoded;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_out_nxt   = OH_NULL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_out_nxt   = OH_NULL;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_out_nxt   = OH_NULL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= OH_NULL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_in_ready = (r_state == ST_IDLE);
    assign o_busy     = (r_state == ST_HOLD);
    assign o_out      = r_out;
    assign o_done     = r_done;

endmodule
